// File: rtl/eth_pkg.sv
// Shared TX-path types: the 74-bit FIFO word, the output FSM states and
// small byte-lane helpers.
package eth_pkg;

  localparam int unsigned ETH_MIN_BYTES = 60;

  typedef struct packed {
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tlast;
    logic        rsvd;
  } txword_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAD  = 2'd2,
    GAP  = 2'd3
  } tx_state_e;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int unsigned i = 0; i < 8; i++) c = c + {3'b000, v[i]};
    return c;
  endfunction

  function automatic logic [63:0] keep_mask(input logic [7:0] k);
    logic [63:0] m;
    for (int unsigned i = 0; i < 8; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

endpackage

// File: rtl/eth_tx_fifo2axis_if.sv
// 64-bit AXI4-Stream bundle between the TX drain stage and the MAC.
interface eth_tx_fifo2axis_if;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tlast;
  logic        tvalid;
  logic        tready;

  modport master (output tdata, tkeep, tlast, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/eth_tx_fifo2axis_outreg.sv
// Single-stage valid/ready output register; payload is held while stalled.
module eth_axis_outreg (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_load,
  input  logic [63:0]                i_tdata,
  input  logic [7:0]                 i_tkeep,
  input  logic                       i_tlast,
  output logic                       o_adv,
  eth_tx_fifo2axis_if.master         m
);

  logic [63:0] r_tdata;
  logic [7:0]  r_tkeep;
  logic        r_tlast;
  logic        r_tvalid;

  assign o_adv = !r_tvalid || m.tready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tdata  <= '0;
      r_tkeep  <= '0;
      r_tlast  <= 1'b0;
      r_tvalid <= 1'b0;
    end else if (o_adv) begin
      r_tvalid <= i_load;
      if (i_load) begin
        r_tdata <= i_tdata;
        r_tkeep <= i_tkeep;
        r_tlast <= i_tlast;
      end
    end
  end

  assign m.tdata  = r_tdata;
  assign m.tkeep  = r_tkeep;
  assign m.tlast  = r_tlast;
  assign m.tvalid = r_tvalid;

endmodule

// File: rtl/eth_tx_fifo2axis.sv
// Drains the shared TX FIFO onto the MAC stream, zero-pads runt frames to
// MIN_BYTES, enforces an inter-frame gap and counts frames / padded frames.
module eth_tx_fifo2axis
  import eth_pkg::*;
#(
  parameter int unsigned MIN_BYTES  = ETH_MIN_BYTES,
  parameter int unsigned GAP_CYCLES = 1,
  parameter int unsigned CNT_W      = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [73:0]        fifo_dout,
  input  logic               fifo_empty,
  output logic               fifo_rd_en,
  eth_tx_fifo2axis_if.master m_axis,
  output logic [CNT_W-1:0]   frame_cnt,
  output logic [CNT_W-1:0]   pad_cnt
);

  tx_state_e        r_state;
  logic [3:0]       r_word_idx;
  logic [3:0]       r_gap_cnt;
  logic [CNT_W-1:0] r_frame_cnt;
  logic [CNT_W-1:0] r_pad_cnt;

  txword_t     w_in;
  logic        w_unused_rsvd;
  logic        w_adv;
  logic        w_pop;
  logic        w_runt;
  logic        w_tlast_hs;
  logic [7:0]  w_bytes;
  logic        w_load;
  logic [63:0] w_out_tdata;
  logic [7:0]  w_out_tkeep;
  logic        w_out_tlast;

  assign w_in          = txword_t'(fifo_dout);
  assign w_unused_rsvd = w_in.rsvd;
  assign w_pop         = (r_state == DATA) && !fifo_empty && w_adv && !rst;
  assign fifo_rd_en    = w_pop;
  assign w_tlast_hs    = m_axis.tvalid && m_axis.tready && m_axis.tlast;

  // word_idx saturates at 8, so any frame past eight words is never a runt
  assign w_bytes = {1'b0, r_word_idx, 3'b000} + {4'b0000, popcount8(w_in.tkeep)};
  assign w_runt  = (w_bytes < 8'(MIN_BYTES)) && (r_word_idx <= 4'd7);

  always_comb begin
    w_load      = 1'b0;
    w_out_tdata = '0;
    w_out_tkeep = '0;
    w_out_tlast = 1'b0;
    if (w_pop) begin
      w_load      = 1'b1;
      w_out_tdata = w_in.tdata;
      w_out_tkeep = w_in.tkeep;
      w_out_tlast = w_in.tlast;
      if (w_in.tlast && w_runt) begin
        w_out_tdata = w_in.tdata & keep_mask(w_in.tkeep);
        if (r_word_idx == 4'd7) begin
          w_out_tkeep = w_in.tkeep | 8'h0F;
          w_out_tlast = 1'b1;
        end else begin
          w_out_tkeep = 8'hFF;
          w_out_tlast = 1'b0;
        end
      end
    end else if ((r_state == PAD) && w_adv) begin
      w_load      = 1'b1;
      w_out_tkeep = (r_word_idx == 4'd7) ? 8'h0F : 8'hFF;
      w_out_tlast = (r_word_idx == 4'd7);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_word_idx  <= '0;
      r_gap_cnt   <= '0;
      r_frame_cnt <= '0;
      r_pad_cnt   <= '0;
    end else begin
      if (w_tlast_hs) r_frame_cnt <= r_frame_cnt + CNT_W'(1);
      unique case (r_state)
        IDLE: begin
          r_word_idx <= '0;
          if (!fifo_empty) r_state <= DATA;
        end
        DATA: begin
          if (w_pop) begin
            if (!w_in.tlast) begin
              if (r_word_idx < 4'd8) r_word_idx <= r_word_idx + 4'd1;
            end else if (!w_runt || (r_word_idx == 4'd7)) begin
              r_state <= GAP;
            end else begin
              r_word_idx <= r_word_idx + 4'd1;
              r_state    <= PAD;
            end
            if (w_in.tlast && w_runt) r_pad_cnt <= r_pad_cnt + CNT_W'(1);
          end
        end
        PAD: begin
          if (w_adv) begin
            if (r_word_idx == 4'd7) r_state <= GAP;
            else r_word_idx <= r_word_idx + 4'd1;
          end
        end
        GAP: begin
          // gap_cnt==0 means still waiting for the tlast beat to be taken
          if (r_gap_cnt != 4'd0) begin
            if (r_gap_cnt == 4'd1) r_state <= IDLE;
            r_gap_cnt <= r_gap_cnt - 4'd1;
          end else if (w_tlast_hs) begin
            if (GAP_CYCLES == 0) r_state <= IDLE;
            else r_gap_cnt <= 4'(GAP_CYCLES);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  eth_axis_outreg u_outreg (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_tdata (w_out_tdata),
    .i_tkeep (w_out_tkeep),
    .i_tlast (w_out_tlast),
    .o_adv   (w_adv),
    .m       (m_axis)
  );

  assign frame_cnt = r_frame_cnt;
  assign pad_cnt   = r_pad_cnt;

endmodule
